// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: button inputs and timer/display outputs of the stopwatch sequencer
// master: board/bench side, drives buttons and observes controls
// slave: controller side, reads buttons and drives tick, timer controls, freeze, lap_count, state
interface stopwatch_ctrl_if #(parameter int LAP_W = 4);
  logic btn_start, btn_stop, btn_lap, btn_clear;
  logic tick, timer_reset, timer_trystart, timer_suspend, freeze;
  logic [LAP_W-1:0] lap_count;
  logic [1:0] state;
  modport master (
    output btn_start, btn_stop, btn_lap, btn_clear,
    input tick, timer_reset, timer_trystart, timer_suspend, freeze, lap_count, state
  );
  modport slave (
    input btn_start, btn_stop, btn_lap, btn_clear,
    output tick, timer_reset, timer_trystart, timer_suspend, freeze, lap_count, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: debounces start/stop/lap/clear and sequences the stopwatch timer
// clock/reset: single clock, synchronous active-low reset
// bus (slave): raw buttons in; tick, timer_reset (active-low), timer_trystart,
//   timer_suspend, freeze, lap_count and state (IDLE=00 RUN=01 PAUSE=10 LAP=11) out
module stopwatch_ctrl #(
  parameter int CLK_DIV = 100,
  parameter int DEBOUNCE = 200,
  parameter int LAP_W = 4
) (
  input logic clock,
  input logic reset,
  stopwatch_ctrl_if.slave bus
);
  localparam int DB_W = $clog2(DEBOUNCE + 1);
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, LAP = 2'b11} state_t;
  state_t state_q, state_d;
  logic [3:0] btn, meta_q, sync_q, stable_q, stable_d, ev_q, ev_d, accept;
  logic [DB_W-1:0] cnt_q [4];
  logic [DB_W-1:0] cnt_d [4];
  logic [DIV_W-1:0] div_q, div_d;
  logic [LAP_W-1:0] lap_q, lap_d;
  logic tick_q, tick_d, trst_q, trst_d, try_q, try_d, susp_q, susp_d, frz_q, frz_d;
  logic clr, stp, sta, lp, running, wrap;
  // bit order: 0 start, 1 stop, 2 lap, 3 clear
  assign btn = {bus.btn_clear, bus.btn_lap, bus.btn_stop, bus.btn_start};
  always_comb begin
    accept = '0;
    for (int i = 0; i < 4; i++) begin
      accept[i] = sync_q[i] != stable_q[i] && cnt_q[i] == DB_W'(DEBOUNCE - 1);
      cnt_d[i] = (sync_q[i] == stable_q[i] || accept[i]) ? '0 : cnt_q[i] + 1'b1;
    end
    stable_d = stable_q ^ accept;
    ev_d = accept & sync_q;
  end
  // priority clear > stop > start > lap; only the winner is seen by the FSM
  assign clr = ev_q[3];
  assign stp = ev_q[1] & ~clr;
  assign sta = ev_q[0] & ~clr & ~ev_q[1];
  assign lp = ev_q[2] & ~clr & ~ev_q[1] & ~ev_q[0];
  assign running = state_q == RUN || state_q == LAP;
  assign wrap = div_q == DIV_W'(CLK_DIV - 1);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = sta ? RUN : IDLE;
      RUN: state_d = stp ? PAUSE : lp ? LAP : RUN;
      PAUSE: state_d = sta ? RUN : PAUSE;
      default: state_d = stp ? PAUSE : (sta | lp) ? RUN : LAP;
    endcase
    if (clr) state_d = IDLE;
    lap_d = clr ? '0 : (state_q == RUN && lp && lap_q != '1) ? lap_q + 1'b1 : lap_q;
    // divider follows the current state so the first tick after a start lands CLK_DIV cycles later
    div_d = (clr || state_q == IDLE) ? '0 : !running ? div_q : wrap ? '0 : div_q + 1'b1;
    tick_d = running && wrap && !clr;
    trst_d = !clr;
    try_d = state_d == RUN || state_d == LAP;
    susp_d = !try_d;
    frz_d = state_d == LAP;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      meta_q <= '0;
      sync_q <= '0;
      stable_q <= '0;
      ev_q <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      state_q <= IDLE;
      div_q <= '0;
      lap_q <= '0;
      tick_q <= 1'b0;
      trst_q <= 1'b0;
      try_q <= 1'b0;
      susp_q <= 1'b1;
      frz_q <= 1'b0;
    end else begin
      meta_q <= btn;
      sync_q <= meta_q;
      stable_q <= stable_d;
      ev_q <= ev_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      state_q <= state_d;
      div_q <= div_d;
      lap_q <= lap_d;
      tick_q <= tick_d;
      trst_q <= trst_d;
      try_q <= try_d;
      susp_q <= susp_d;
      frz_q <= frz_d;
    end
  end
  assign bus.tick = tick_q;
  assign bus.timer_reset = trst_q;
  assign bus.timer_trystart = try_q;
  assign bus.timer_suspend = susp_q;
  assign bus.freeze = frz_q;
  assign bus.lap_count = lap_q;
  assign bus.state = state_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed scenarios plus randomized buttons against a reference model
module tb_stopwatch_ctrl;
  localparam int CLK_DIV = 4, DEBOUNCE = 3, LAP_W = 4, LAP_MAX = (1 << LAP_W) - 1;
  logic clock = 0, reset = 0;
  int errors = 0, checks = 0;
  stopwatch_ctrl_if #(.LAP_W(LAP_W)) bus ();
  stopwatch_ctrl #(.CLK_DIV(CLK_DIV), .DEBOUNCE(DEBOUNCE), .LAP_W(LAP_W)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
  always #5 clock = ~clock;
  // reference model: button level history, mismatch run lengths, and a state table
  logic [3:0] m_d1, m_d2, m_stab, m_ev, raw;
  int m_run [4];
  int m_w, m_lap, m_div;
  logic [1:0] m_state, m_ns;
  logic m_tick, m_trst, m_try, m_susp, m_frz, m_running;
  assign raw = {bus.btn_clear, bus.btn_lap, bus.btn_stop, bus.btn_start};
  always @(posedge clock) begin
    if (!reset) begin
      m_d1 = 0; m_d2 = 0; m_stab = 0; m_ev = 0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_state = 0; m_lap = 0; m_div = 0;
      m_tick = 0; m_trst = 0; m_try = 0; m_susp = 1; m_frz = 0;
    end else begin
      m_w = m_ev[3] ? 3 : m_ev[1] ? 1 : m_ev[0] ? 0 : m_ev[2] ? 2 : -1;
      m_ns = m_state;
      if (m_w == 3) m_ns = 0;
      else if (m_w == 0 && m_state != 1) m_ns = 1;
      else if (m_w == 1 && (m_state == 1 || m_state == 3)) m_ns = 2;
      else if (m_w == 2 && m_state == 1) m_ns = 3;
      else if (m_w == 2 && m_state == 3) m_ns = 1;
      m_running = m_state == 1 || m_state == 3;
      m_tick = m_running && m_div == CLK_DIV - 1 && m_w != 3;
      if (m_w == 2 && m_state == 1 && m_lap < LAP_MAX) m_lap++;
      if (m_w == 3) m_lap = 0;
      if (m_w == 3 || m_state == 0) m_div = 0;
      else if (m_running) m_div = (m_div + 1) % CLK_DIV;
      m_trst = m_w != 3;
      m_state = m_ns;
      m_try = m_ns == 1 || m_ns == 3;
      m_susp = !m_try;
      m_frz = m_ns == 3;
      for (int i = 0; i < 4; i++) begin
        m_ev[i] = 0;
        if (m_d2[i] !== m_stab[i]) begin
          m_run[i]++;
          if (m_run[i] == DEBOUNCE) begin
            m_stab[i] = m_d2[i];
            m_run[i] = 0;
            m_ev[i] = m_d2[i];
          end
        end else m_run[i] = 0;
      end
      m_d2 = m_d1;
      m_d1 = raw;
    end
  end
  task automatic set_btn(input logic [3:0] m);
    {bus.btn_clear, bus.btn_lap, bus.btn_stop, bus.btn_start} = m;
  endtask
  // returns at the negedge right after the edge on which the FSM acts
  task automatic press(input logic [3:0] m);
    repeat (4) @(negedge clock);
    set_btn(m);
    repeat (5) @(negedge clock);
    set_btn(4'b0);
    @(negedge clock);
  endtask
  task automatic test_reset;
    reset = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clock);
      checks++;
      if ({bus.state, bus.timer_suspend, bus.timer_trystart, bus.timer_reset, bus.tick, bus.freeze, bus.lap_count} !== {2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0}) begin
        errors++;
        $display("FAIL reset_held: state=%b susp=%b try=%b trst=%b tick=%b frz=%b lap=%0d", bus.state, bus.timer_suspend, bus.timer_trystart, bus.timer_reset, bus.tick, bus.freeze, bus.lap_count);
      end
    end
    reset = 1;
    @(negedge clock);
    checks++;
    if (bus.timer_reset !== 1'b1) begin errors++; $display("FAIL reset_release_trst: got %b expected 1", bus.timer_reset); end
    checks++;
    if (bus.state !== 2'b00) begin errors++; $display("FAIL reset_release_state: got %b expected 00", bus.state); end
  endtask
  task automatic test_debounce;
    bus.btn_start = 1;
    repeat (2) @(negedge clock);
    bus.btn_start = 0;
    repeat (10) @(negedge clock);
    checks++;
    if (bus.state !== 2'b00) begin errors++; $display("FAIL short_pulse: state=%b expected 00", bus.state); end
    bus.btn_start = 1;
    repeat (5) @(negedge clock);
    checks++;
    if (bus.state !== 2'b00) begin errors++; $display("FAIL start_edge4: state=%b expected 00", bus.state); end
    @(negedge clock);
    checks++;
    if ({bus.state, bus.timer_trystart, bus.timer_suspend} !== {2'b01, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL start_edge5: state=%b try=%b susp=%b expected 01 1 0", bus.state, bus.timer_trystart, bus.timer_suspend);
    end
  endtask
  task automatic test_tick;
    int nt = 0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clock);
      if (j == 4) bus.btn_start = 0;
      checks++;
      if (bus.tick !== 1'(j % 4 == 0)) begin errors++; $display("FAIL tick_at_%0d: got %b expected %b", j, bus.tick, j % 4 == 0); end
      nt += int'(bus.tick);
    end
    checks++;
    if (nt != 5) begin errors++; $display("FAIL tick_count: got %0d expected 5", nt); end
  endtask
  task automatic test_pause;
    press(4'b0010);
    checks++;
    if ({bus.state, bus.tick, bus.timer_suspend, bus.timer_trystart} !== {2'b10, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL pause_enter: state=%b tick=%b susp=%b try=%b", bus.state, bus.tick, bus.timer_suspend, bus.timer_trystart);
    end
    for (int j = 0; j < 12; j++) begin
      @(negedge clock);
      checks++;
      if ({bus.state, bus.tick} !== {2'b10, 1'b0}) begin errors++; $display("FAIL pause_hold_%0d: state=%b tick=%b expected 10 0", j, bus.state, bus.tick); end
    end
    press(4'b0001);
    checks++;
    if ({bus.state, bus.tick} !== {2'b01, 1'b0}) begin errors++; $display("FAIL resume: state=%b tick=%b expected 01 0", bus.state, bus.tick); end
    for (int j = 1; j <= 3; j++) begin
      @(negedge clock);
      checks++;
      if (bus.tick !== 1'(j == 2)) begin errors++; $display("FAIL resume_tick_%0d: got %b expected %b", j, bus.tick, j == 2); end
    end
  endtask
  task automatic test_lap;
    press(4'b0100);
    checks++;
    if ({bus.state, bus.freeze, bus.lap_count, bus.timer_trystart} !== {2'b11, 1'b1, 4'd1, 1'b1}) begin
      errors++;
      $display("FAIL lap_enter: state=%b frz=%b lap=%0d try=%b", bus.state, bus.freeze, bus.lap_count, bus.timer_trystart);
    end
    press(4'b0100);
    checks++;
    if ({bus.state, bus.freeze, bus.lap_count} !== {2'b01, 1'b0, 4'd1}) begin
      errors++;
      $display("FAIL lap_exit: state=%b frz=%b lap=%0d expected 01 0 1", bus.state, bus.freeze, bus.lap_count);
    end
    for (int k = 1; k <= 20; k++) begin
      press(4'b0100);
      checks++;
      if ({bus.state, bus.lap_count} !== {2'b11, 4'((k + 1 > LAP_MAX) ? LAP_MAX : k + 1)}) begin
        errors++;
        $display("FAIL lap_sat_%0d: state=%b lap=%0d", k, bus.state, bus.lap_count);
      end
      press(4'b0100);
    end
    checks++;
    if ({bus.state, bus.lap_count} !== {2'b01, 4'd15}) begin errors++; $display("FAIL lap_final: state=%b lap=%0d expected 01 15", bus.state, bus.lap_count); end
  endtask
  task automatic test_clear;
    press(4'b1001);
    checks++;
    if ({bus.state, bus.timer_reset, bus.lap_count, bus.tick, bus.timer_suspend} !== {2'b00, 1'b0, 4'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL clear_edge: state=%b trst=%b lap=%0d tick=%b susp=%b", bus.state, bus.timer_reset, bus.lap_count, bus.tick, bus.timer_suspend);
    end
    for (int j = 0; j < 6; j++) begin
      @(negedge clock);
      checks++;
      if ({bus.state, bus.timer_reset, bus.tick} !== {2'b00, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL clear_after_%0d: state=%b trst=%b tick=%b expected 00 1 0", j, bus.state, bus.timer_reset, bus.tick);
      end
    end
  endtask
  task automatic test_reset_mid;
    press(4'b0001);
    press(4'b0100);
    checks++;
    if (bus.state !== 2'b11) begin errors++; $display("FAIL mid_lap_setup: state=%b expected 11", bus.state); end
    bus.btn_stop = 1;
    repeat (5) @(negedge clock);
    reset = 0;
    @(negedge clock);
    checks++;
    if ({bus.state, bus.tick, bus.timer_reset, bus.timer_trystart, bus.timer_suspend, bus.freeze, bus.lap_count} !== {2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL mid_reset: state=%b tick=%b trst=%b try=%b susp=%b frz=%b lap=%0d", bus.state, bus.tick, bus.timer_reset, bus.timer_trystart, bus.timer_suspend, bus.freeze, bus.lap_count);
    end
    bus.btn_stop = 0;
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    checks++;
    if ({bus.state, bus.timer_reset} !== {2'b00, 1'b1}) begin errors++; $display("FAIL mid_reset_release: state=%b trst=%b expected 00 1", bus.state, bus.timer_reset); end
  endtask
  task automatic test_random;
    int hold [4] = '{0, 0, 0, 0};
    logic [3:0] b = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      checks++;
      if ({bus.state, bus.tick, bus.timer_reset, bus.timer_trystart, bus.timer_suspend, bus.freeze, bus.lap_count} !== {m_state, m_tick, m_trst, m_try, m_susp, m_frz, 4'(m_lap)}) begin
        errors++;
        $display("FAIL random_%0d: got st=%b tk=%b tr=%b ts=%b su=%b fz=%b lap=%0d expected st=%b tk=%b tr=%b ts=%b su=%b fz=%b lap=%0d", n,
          bus.state, bus.tick, bus.timer_reset, bus.timer_trystart, bus.timer_suspend, bus.freeze, bus.lap_count,
          m_state, m_tick, m_trst, m_try, m_susp, m_frz, m_lap);
      end
      reset = $urandom_range(0, 599) != 0;
      for (int i = 0; i < 4; i++) begin
        if (hold[i] == 0) begin
          b[i] = 1'($urandom_range(0, 1));
          hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : $urandom_range(3, 12);
        end else hold[i]--;
      end
      set_btn(b);
    end
    reset = 1;
  endtask
  initial begin
    set_btn(4'b0);
    test_reset;
    test_debounce;
    test_tick;
    test_pause;
    test_lap;
    test_clear;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
